gfx_cmd_scheduler: RTL and testbench

//  Sequences 52-bit draw commands into the graphics engine from two requesters:
//  the host command port and the LFSR demo command generator. Arbitrates

---
 rtl/gfx_cmd_scheduler.sv | 106 ++++++++++
 tb/tb_gfx_cmd_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gfx_cmd_scheduler.sv
// gfx_cmd_scheduler: round-robin sequencer feeding draw commands from the host
// port and the demo generator into the graphics engine, one command at a time.
module gfx_cmd_scheduler #(
    parameter int CMD_W    = 52,
    parameter int DEMO_GAP = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             host_valid,
    input  logic [CMD_W-1:0] host_cmd,
    output logic             host_ready,
    input  logic [CMD_W-1:0] demo_cmd,
    output logic             demo_step,
    output logic             eng_valid,
    output logic [CMD_W-1:0] eng_cmd,
    input  logic             eng_ready,
    input  logic             eng_busy,
    output logic             cmd_src,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             busy
);

    // gap counter must hold DEMO_GAP; keep at least one bit when the gap is disabled
    localparam int GAP_W = (DEMO_GAP > 0) ? $clog2(DEMO_GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC} state_t;

    state_t           state, state_nxt;
    logic [CMD_W-1:0] cmd_q;
    logic             src_q;
    logic             last_src;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_cnt;

    logic host_req, demo_req, grant_host, grant_demo, accept, exec_done;

    // Request/grant: on a tie the source that did not win last time gets it
    always_comb begin
        host_req   = host_valid;
        demo_req   = mode && (gap_cnt == '0);
        grant_host = (state == S_IDLE) && host_req && (!demo_req || last_src);
        grant_demo = (state == S_IDLE) && demo_req && (!host_req || !last_src);
        accept     = (state == S_ISSUE) && eng_ready;
        // EXEC always lasts at least one cycle; busy is looked at on the edge
        // that closes each EXEC cycle
        exec_done  = (state == S_EXEC) && !eng_busy;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt  = state;
        host_ready = 1'b0;
        case (state)
            S_IDLE: begin
                // a host that loses the tie must not see a transfer
                host_ready = !rst && !(host_req && grant_demo);
                if (grant_host || grant_demo) state_nxt = S_ISSUE;
            end
            S_ISSUE: if (eng_ready) state_nxt = S_EXEC;
            S_EXEC:  if (!eng_busy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        eng_valid  = (state == S_ISSUE);
        eng_cmd    = cmd_q;
        cmd_src    = src_q;
        issued_cnt = cnt_q;
        busy       = (state != S_IDLE);
        // reset in the acceptance cycle cancels the generator advance
        demo_step  = accept && src_q && !rst;
    end

    // State, latched command, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd_q    <= '0;
            src_q    <= 1'b0;
            last_src <= 1'b1;
            cnt_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_host) begin
                cmd_q <= host_cmd;
                src_q <= 1'b0;
            end else if (grant_demo) begin
                cmd_q <= demo_cmd;
                src_q <= 1'b1;
            end
            if (accept) begin
                cnt_q    <= cnt_q + 1'b1;
                last_src <= src_q;
            end
            // leaving demo mode drops any pending gap
            if (!mode)
                gap_cnt <= '0;
            else if (exec_done && src_q)
                gap_cnt <= GAP_W'(DEMO_GAP);
            else if ((state == S_IDLE) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// tb_gfx_cmd_scheduler: directed phases plus a random soak, every cycle checked
// against a transaction-level model of the scheduler.
module tb_gfx_cmd_scheduler;

    localparam int CMD_W    = 52;
    localparam int DEMO_GAP = 16;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst, mode, host_valid, eng_ready, eng_busy;
    logic [CMD_W-1:0] host_cmd, demo_cmd;
    logic             host_ready, demo_step, eng_valid, cmd_src, busy;
    logic [CMD_W-1:0] eng_cmd;
    logic [CNT_W-1:0] issued_cnt;

    gfx_cmd_scheduler #(.CMD_W(CMD_W), .DEMO_GAP(DEMO_GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .host_valid(host_valid), .host_cmd(host_cmd),
        .host_ready(host_ready), .demo_cmd(demo_cmd), .demo_step(demo_step),
        .eng_valid(eng_valid), .eng_cmd(eng_cmd), .eng_ready(eng_ready), .eng_busy(eng_busy),
        .cmd_src(cmd_src), .issued_cnt(issued_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    // model: a command is either absent, offered to the engine, or executing
    bit             m_offer, m_exec, m_src, m_last;
    logic [CMD_W-1:0] m_cmd;
    int             m_cnt, m_gap;
    bit             prev_offer;
    int             rises[$];
    bit             acc_src[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] lfsr(input logic [CMD_W-1:0] v);
        return {v[CMD_W-2:0], v[51] ^ v[48]};
    endfunction

    task automatic model_reset();
        m_offer = 0; m_exec = 0; m_src = 0; m_last = 1;
        m_cmd = '0; m_cnt = 0; m_gap = 0;
    endtask

    // one clock: check outputs against the model, then advance model and demo source
    task automatic step();
        bit idle, hreq, dreq, g_host, g_demo, exp_ds, acc;
        #2;
        idle   = !m_offer && !m_exec;
        hreq   = host_valid;
        dreq   = mode && (m_gap == 0);
        g_demo = idle && dreq && (!hreq || !m_last);
        g_host = idle && hreq && (!dreq || m_last);
        acc    = m_offer && eng_ready;
        exp_ds = acc && m_src && !rst;
        chk("host_ready", 64'(host_ready), 64'(idle && !rst && !(hreq && g_demo)));
        chk("eng_valid",  64'(eng_valid),  64'(m_offer));
        chk("eng_cmd",    64'(eng_cmd),    64'(m_cmd));
        chk("cmd_src",    64'(cmd_src),    64'(m_src));
        chk("demo_step",  64'(demo_step),  64'(exp_ds));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_cnt));
        chk("busy",       64'(busy),       64'(!idle));
        if (m_offer && !prev_offer) rises.push_back(cyc);
        prev_offer = m_offer;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!mode) m_gap = 0;
            else if (m_exec && !eng_busy && m_src) m_gap = DEMO_GAP;
            else if (idle && m_gap > 0) m_gap--;
            if (m_exec && !eng_busy) m_exec = 0;
            if (acc) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_last = m_src; m_offer = 0; m_exec = 1;
                acc_src.push_back(m_src);
            end
            if (g_host) begin m_cmd = host_cmd; m_src = 0; m_offer = 1; end
            if (g_demo) begin m_cmd = demo_cmd; m_src = 1; m_offer = 1; end
        end
        #1;
        if (exp_ds) demo_cmd = lfsr(demo_cmd);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        rst = 1; mode = 0; host_valid = 0; host_cmd = '0; eng_ready = 0; eng_busy = 0;
        demo_cmd = 52'h0_0000_0000_ACE1;
        model_reset();
        prev_offer = 0;
        @(posedge clk); #1;
        // reset state
        do_reset();

        // 1: single host command, one-cycle grant latency
        host_valid = 1; host_cmd = 52'h1; eng_ready = 1;
        step();
        host_valid = 0;
        chk("t1_valid_after_grant", 64'(eng_valid), 64'd1);
        chk("t1_cmd", 64'(eng_cmd), 64'h1);
        steps(4);
        chk("t1_cnt", 64'(issued_cnt), 64'd1);

        // 2: demo only, fixed 19-cycle cadence
        rises.delete();
        mode = 1;
        steps(100);
        chk("t2_rises", 64'(rises.size() >= 5), 64'd1);
        for (int i = 1; i < rises.size(); i++)
            chk("t2_period", 64'(rises[i] - rises[i-1]), 64'd19);

        // 3: both requesting, host first after reset, then demo
        do_reset();
        acc_src.delete();
        mode = 1; host_valid = 1;
        for (int i = 0; i < 30; i++) begin host_cmd = {$urandom, $urandom}; step(); end
        host_valid = 0;
        chk("t3_first_src", 64'(acc_src[0]), 64'd0);
        chk("t3_second_src", 64'(acc_src[1]), 64'd1);

        // 4: engine stalls 10 cycles in ISSUE
        do_reset();
        mode = 0; host_valid = 1; host_cmd = {$urandom, $urandom}; eng_ready = 0;
        step();
        host_valid = 0;
        steps(10);
        chk("t4_held_valid", 64'(eng_valid), 64'd1);
        chk("t4_held_cnt", 64'(issued_cnt), 64'd0);
        eng_ready = 1;
        steps(3);
        chk("t4_cnt", 64'(issued_cnt), 64'd1);

        // 5: reset in ISSUE of a demo command
        do_reset();
        mode = 1; eng_ready = 0;
        steps(2);
        chk("t5_demo_issue", 64'(eng_valid && cmd_src), 64'd1);
        eng_ready = 1; rst = 1;
        step();
        rst = 0; mode = 0;
        chk("t5_valid_cleared", 64'(eng_valid), 64'd0);
        chk("t5_cnt_cleared", 64'(issued_cnt), 64'd0);
        host_valid = 1; host_cmd = {$urandom, $urandom};
        step();
        host_valid = 0;
        steps(3);
        chk("t5_host_after_rst", 64'(issued_cnt), 64'd1);

        // engine busy stuck high keeps the scheduler in EXEC
        eng_busy = 1; host_valid = 1;
        steps(3);
        steps(20);
        chk("busy_stuck", 64'(busy), 64'd1);
        eng_busy = 0; host_valid = 0;
        steps(3);

        // 6: issued counter wraps to zero
        do_reset();
        host_valid = 1; eng_ready = 1;
        for (int g = 0; g < 4000 && m_cnt != (1 << CNT_W) - 1; g++) begin
            host_cmd = {$urandom, $urandom}; step();
        end
        chk("t6_reached_max", 64'(issued_cnt), 64'((1 << CNT_W) - 1));
        for (int g = 0; g < 10 && m_cnt != 0; g++) step();
        chk("t6_wrap", 64'(issued_cnt), 64'd0);
        host_valid = 0;

        // random soak
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            mode       = ($urandom_range(0, 9) < 7);
            host_valid = $urandom_range(0, 1);
            host_cmd   = {$urandom, $urandom};
            eng_ready  = $urandom_range(0, 1);
            eng_busy   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
